// File: rtl/fa_bist_pkg.sv
// fa_bist_pkg: shared types and sizes for the full-adder BIST controller.
//   state_t : controller FSM states
//   NUM_VEC : number of exhaustive {a,b,cin} vectors
//   VEC_W   : width of the vector index
//   ERR_W   : width of the error counter (holds 0..NUM_VEC)
package fa_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;
    localparam int ERR_W   = 4;

endpackage

// File: rtl/fa_golden.sv
// fa_golden: combinational reference single-bit full adder.
//   a, b, cin : operand bits
//   exp_sum   : a ^ b ^ cin
//   exp_cout  : majority(a, b, cin)
module fa_golden (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic exp_sum,
    output logic exp_cout
);

    assign exp_sum  = a ^ b ^ cin;
    assign exp_cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_bist.sv
// fa_bist: built-in self-test controller for an external full adder.
// Walks all eight {a,b,cin} vectors, holds each for DWELL cycles, then
// samples sum/cout and compares against fa_golden.
//   clk, rst_n       : clock, async active-low reset
//   start            : run request, honoured only in IDLE
//   a, b, cin        : registered stimulus to the adder under test
//   sum, cout        : adder under test responses
//   busy             : run in progress (APPLY/CHECK)
//   done             : one-cycle end-of-run pulse
//   pass             : last completed run had no errors
//   err_count        : mismatching vectors this/last run
//   fail_valid       : a mismatch has been recorded this run
//   fail_vec         : {a,b,cin} of the first mismatch
module fa_bist
    import fa_bist_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             cin,
    input  logic             sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec
);

    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
    localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(NUM_VEC - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [7:0]         dwell_q, dwell_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fvalid_q, fvalid_d;
    logic [VEC_W-1:0]   fvec_q, fvec_d;
    logic               pass_q, pass_d;
    logic [VEC_W-1:0]   abc_q, abc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic exp_sum, exp_cout, mismatch;

    // Reference is driven from the registered stimulus, so it always sees
    // exactly what the adder under test sees.
    fa_golden u_golden (
        .a        (abc_q[2]),
        .b        (abc_q[1]),
        .cin      (abc_q[0]),
        .exp_sum  (exp_sum),
        .exp_cout (exp_cout)
    );

    assign mismatch = (sum != exp_sum) || (cout != exp_cout);

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        dwell_d  = dwell_q;
        err_d    = err_q;
        fvalid_d = fvalid_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = APPLY;
                    vec_d    = '0;
                    dwell_d  = '0;
                    err_d    = '0;
                    fvalid_d = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            APPLY: begin
                dwell_d = dwell_q + 8'd1;
                if (dwell_q == DWELL_LAST) state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + ERR_W'(1);
                    if (!fvalid_q) begin
                        fvalid_d = 1'b1;
                        fvec_d   = vec_q;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                    // Resolve pass here so it is already valid in the done cycle.
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    dwell_d = '0;
                    state_d = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
                vec_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe and never glitch toward the adder.
    always_comb begin
        busy_d = (state_d == APPLY) || (state_d == CHECK);
        done_d = (state_d == DONE);
        abc_d  = busy_d ? vec_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            dwell_q  <= '0;
            err_q    <= '0;
            fvalid_q <= 1'b0;
            fvec_q   <= '0;
            pass_q   <= 1'b0;
            abc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            dwell_q  <= dwell_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            fvec_q   <= fvec_d;
            pass_q   <= pass_d;
            abc_q    <= abc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign a          = abc_q[2];
    assign b          = abc_q[1];
    assign cin        = abc_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fvalid_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_fa_bist.sv
// tb_fa_bist: scoreboard bench for fa_bist. Two instances (DWELL=4 and
// DWELL=1) each drive a bench adder that can be switched between correct,
// sum-stuck-at-0 and cout-stuck-at-0 behaviour.
module tb_fa_bist;

    typedef struct {
        int         cyc;
        logic       pass;
        logic [3:0] err;
        logic       fvalid;
        logic [2:0] fvec;
    } exp_t;

    logic clk, rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // DWELL=4 instance
    logic       start4, a4, b4, cin4, sum4, cout4, busy4, done4, pass4, fv4;
    logic [3:0] err4;
    logic [2:0] fvec4;
    int         mode4;
    // DWELL=1 instance
    logic       start1, a1, b1, cin1, sum1, cout1, busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] fvec1;
    int         mode1;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;

    // mode 0: correct, 1: sum stuck at 0, 2: cout stuck at 0
    assign sum4  = (mode4 == 1) ? 1'b0 : (a4 ^ b4 ^ cin4);
    assign cout4 = (mode4 == 2) ? 1'b0 : ((a4 & b4) | (a4 & cin4) | (b4 & cin4));
    assign sum1  = (mode1 == 1) ? 1'b0 : (a1 ^ b1 ^ cin1);
    assign cout1 = (mode1 == 2) ? 1'b0 : ((a1 & b1) | (a1 & cin1) | (b1 & cin1));

    fa_bist #(.DWELL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(cout4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .fail_valid(fv4), .fail_vec(fvec4)
    );

    fa_bist #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_vec(fvec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                chk("done4_unexpected", 1, 0);
            end else begin
                e4 = q4.pop_front();
                chk("done4_cycle", cyc, e4.cyc);
                chk("pass4", pass4, e4.pass);
                chk("err4", err4, e4.err);
                chk("fvalid4", fv4, e4.fvalid);
                if (e4.fvalid) chk("fvec4", fvec4, e4.fvec);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                chk("done1_unexpected", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("done1_cycle", cyc, e1.cyc);
                chk("pass1", pass1, e1.pass);
                chk("err1", err1, e1.err);
                chk("fvalid1", fv1, e1.fvalid);
                if (e1.fvalid) chk("fvec1", fvec1, e1.fvec);
            end
        end
    end

    // One DWELL=4 run: done lands 41 cycles after the start-sampling cycle.
    task automatic run4(input int mode, input logic ep, input logic [3:0] ee,
                        input logic efv, input logic [2:0] efvec, input bit restart);
        exp_t e;
        @(negedge clk);
        mode4  = mode;
        start4 = 1'b1;
        e.cyc = cyc + 41; e.pass = ep; e.err = ee; e.fvalid = efv; e.fvec = efvec;
        q4.push_back(e);
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            start4 = restart && (c == 10);
            chk("busy4", busy4, (c <= 40) ? 1 : 0);
            chk("abc4", {a4, b4, cin4}, (c <= 40) ? (c - 1) / 5 : 0);
            if (c == 1) begin
                chk("err4_cleared", err4, 0);
                chk("fvalid4_cleared", fv4, 0);
                chk("pass4_cleared", pass4, 0);
            end
        end
    endtask

    task automatic chk_reset4(input string tag);
        chk({tag, "_abc"}, {a4, b4, cin4}, 0);
        chk({tag, "_busy"}, busy4, 0);
        chk({tag, "_done"}, done4, 0);
        chk({tag, "_pass"}, pass4, 0);
        chk({tag, "_err"}, err4, 0);
        chk({tag, "_fvalid"}, fv4, 0);
        chk({tag, "_fvec"}, fvec4, 0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0; mode4 = 0; mode1 = 0;
        repeat (2) @(negedge clk);
        chk_reset4("rst4");
        chk("rst1_busy", busy1, 0);
        chk("rst1_err", err1, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // correct adder
        run4(0, 1'b1, 4'd0, 1'b0, 3'd0, 1'b0);
        // sum stuck at 0: errors on 001,010,100,111
        run4(1, 1'b0, 4'd4, 1'b1, 3'b001, 1'b0);
        // correct adder swapped back in: old results cleared
        run4(0, 1'b1, 4'd0, 1'b0, 3'd0, 1'b0);
        // faulty run with a stray start at cycle 10
        run4(1, 1'b0, 4'd4, 1'b1, 3'b001, 1'b1);

        // DWELL=1, cout stuck at 0: errors on 011,101,110,111, done at cycle 17
        @(negedge clk);
        mode1 = 2; start1 = 1'b1;
        e.cyc = cyc + 17; e.pass = 1'b0; e.err = 4'd4; e.fvalid = 1'b1; e.fvec = 3'b011;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        repeat (20) @(negedge clk);

        // start held high: back-to-back runs, second done 18 cycles later
        mode1 = 0; start1 = 1'b1;
        e.cyc = cyc + 17; e.pass = 1'b1; e.err = 4'd0; e.fvalid = 1'b0; e.fvec = 3'd0;
        q1.push_back(e);
        e.cyc = cyc + 35;
        q1.push_back(e);
        repeat (25) @(negedge clk);
        start1 = 1'b0;
        repeat (15) @(negedge clk);

        // reset mid-run after errors have been recorded
        @(negedge clk);
        mode4 = 1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_err4", err4, 2);
        chk("mid_fvalid4", fv4, 1);
        chk("mid_fvec4", fvec4, 1);
        chk("mid_busy4", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk_reset4("abort4");
        repeat (3) @(negedge clk);
        chk("abort4_done_held", done4, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run4(0, 1'b1, 4'd0, 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 200 && (q4.size() + q1.size()) != 0; i++) @(negedge clk);
        chk("scoreboard_drain", q4.size() + q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
